gpr_wport_arb: RTL
==================

Name: gpr_wport_arb

Overview:
- Arbitrates the single GPR-file write port between two sources:
  - the in-order pipeline writeback stage, which has fixed top priority and no backpressure;
  - long-latency result producers (divider, load-miss return) via a valid/ready interface.
- Long-latency results are buffered in a small in-order FIFO and drained into idle write-port cycles.
- Reports pending-write hazards to decode, and requests a pipeline stall when a buffered result starves.

Parameters:
- DEPTH, 2, FIFO entries for long-latency results (power of two, ≥2).
- STARVE_LIMIT, 8, consecutive blocked cycles of a live FIFO head before STALL_REQ asserts (≥1).

Ports:
- CLK  input  1  clock
- RST  input  1  synchronous, active-high reset
- P_WE  input  1  pipeline writeback valid
- P_WADDR  input  5  pipeline destination register
- P_WDATA  input  32  pipeline write data
- L_VALID  input  1  long-latency result valid
- L_READY  output  1  FIFO can accept
- L_WADDR  input  5  long-latency destination register
- L_WDATA  input  32  long-latency write data
- WE  output  1  to GPR file write enable
- WADDR  output  5  to GPR file write address
- WDATA  output  32  to GPR file write data
- RADDR1  input  5  decode read address 1
- RADDR2  input  5  decode read address 2
- PEND_HIT1  output  1  live pending write to RADDR1
- PEND_HIT2  output  1  live pending write to RADDR2
- STALL_REQ  output  1  request pipeline to insert a writeback bubble

Behaviour:
- Clock and reset: CLK, rising edge. RST is synchronous, active-high.
- Reset:
  - FIFO count=0, all kill bits=0, starve counter=0, STALL_REQ=0.
  - While RST=1: WE=0, L_READY=0, PEND_HIT1/2=0.
- Pipeline busy: "p_busy" = P_WE & (P_WADDR≠0). An address-0 write counts as no write.
- Enqueue:
  - Occurs when L_VALID & L_READY.
  - L_READY = (count<DEPTH), computed from the registered count only. A pop in the same cycle does not free a slot.
  - L_WADDR=0: the handshake completes but nothing is stored.
- Kill bit:
  - Any live entry whose address equals P_WADDR while p_busy sets its kill bit. The pipeline write is newer.
  - An entry enqueued in the same cycle as a p_busy write to the same address is stored already killed.
- Write-port mux:
  - If p_busy: WE=1, WADDR/WDATA = P_*.
  - Else, if the FIFO is non-empty and the head is not killed: WE=1, WADDR/WDATA = head.
  - Else: WE=0, WADDR/WDATA=0.
- Pop:
  - Head pops when it is written (not p_busy).
  - A killed head pops without a write in any cycle, including p_busy cycles.
  - At most one pop per cycle.
- Latency: an entry accepted at edge N is written no earlier than the cycle after N.
- Ordering:
  - Strict FIFO order among long-latency results.
  - Enqueue and pop may occur in the same cycle; count is unchanged.
- Hazard outputs:
  - PEND_HITx = 1 if any valid, non-killed entry has address = RADDRx, and RADDRx≠0. Combinational.
  - Entries enqueued this cycle are not visible until the next cycle.
- Starve counter:
  - Increments each cycle the head is live and blocked by p_busy.
  - Clears on pop or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- STALL_REQ:
  - Registered. Sets when the counter reaches STARVE_LIMIT.
  - Clears the cycle after the head pops.
  - If the pipeline still asserts p_busy while STALL_REQ=1, the pipeline still wins; nothing is dropped.
- Reset mid-operation: all FIFO contents are discarded; no write occurs on the reset cycle.

Test Plan:
- Reset, then idle inputs → WE=0, L_READY=1, STALL_REQ=0, PEND_HIT1/2=0.
- Enqueue L (r5, 0xDEADBEEF) with P idle → next cycle WE=1, WADDR=5, WDATA=0xDEADBEEF; during the wait, PEND_HIT1=1 for RADDR1=5.
- DEPTH=2: fill with r3 and r4 while P writes every cycle → L_READY=0 on the third offer. After STARVE_LIMIT=8 blocked cycles, STALL_REQ=1. Dropping P_WE → r3 then r4 written in successive cycles. STALL_REQ clears one cycle after r3 pops.
- Enqueue r7=0x11 while P is busy writing r9, then P writes r7=0x22 → entry killed, PEND_HIT for r7 drops to 0, and no later GPR write of r7.
- Same-cycle L enqueue r6=0xAA and P write r6=0xBB → WE writes 0xBB; the entry pops with no write.
- L enqueue r0=0x55 → handshake completes, FIFO stays empty, no write to r0. Then RST asserted with 2 entries queued → count=0 and WE=0 on the next cycle.

Source files
------------

// File: rtl/gpr_wport_arb.sv
// Single GPR write-port arbiter: the pipeline writeback always wins; long-latency
// results wait in a small in-order FIFO and drain into idle write-port cycles.
module gpr_wport_arb #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        P_WE,
    input  logic [4:0]  P_WADDR,
    input  logic [31:0] P_WDATA,
    input  logic        L_VALID,
    output logic        L_READY,
    input  logic [4:0]  L_WADDR,
    input  logic [31:0] L_WDATA,
    output logic        WE,
    output logic [4:0]  WADDR,
    output logic [31:0] WDATA,
    input  logic [4:0]  RADDR1,
    input  logic [4:0]  RADDR2,
    output logic        PEND_HIT1,
    output logic        PEND_HIT2,
    output logic        STALL_REQ
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    // Handshake: a long-latency result transfers on a rising CLK edge where
    // L_VALID and L_READY are both high; L_READY depends only on registered state.

    logic [4:0]       q_addr [DEPTH];
    logic [31:0]      q_data [DEPTH];
    logic [DEPTH-1:0] q_valid;
    logic [DEPTH-1:0] q_kill;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic [SW-1:0]    starve_cnt;
    logic [SW-1:0]    starve_nxt;
    logic             stall_q;

    logic p_busy;
    logic not_empty;
    logic head_kill;
    logic head_live;
    logic enq;
    logic store;
    logic pop;
    logic blocked;
    logic hit1_any;
    logic hit2_any;

    assign p_busy    = P_WE && (P_WADDR != 5'd0);
    assign not_empty = (count != '0);
    assign head_kill = q_kill[rd_ptr];
    assign head_live = not_empty && !head_kill;
    assign L_READY   = !RST && (count < CW'(DEPTH));
    assign enq       = L_VALID && L_READY;
    assign store     = enq && (L_WADDR != 5'd0);
    // A killed head leaves even while the pipeline owns the port.
    assign pop       = not_empty && (head_kill || !p_busy);
    assign blocked   = head_live && p_busy;
    assign STALL_REQ = stall_q;

    always_comb begin
        WE    = 1'b0;
        WADDR = 5'd0;
        WDATA = 32'd0;
        if (!RST) begin
            if (p_busy) begin
                WE    = 1'b1;
                WADDR = P_WADDR;
                WDATA = P_WDATA;
            end else if (head_live) begin
                WE    = 1'b1;
                WADDR = q_addr[rd_ptr];
                WDATA = q_data[rd_ptr];
            end
        end
    end

    always_comb begin
        hit1_any = 1'b0;
        hit2_any = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (q_valid[i] && !q_kill[i] && (q_addr[i] == RADDR1)) hit1_any = 1'b1;
            if (q_valid[i] && !q_kill[i] && (q_addr[i] == RADDR2)) hit2_any = 1'b1;
        end
    end

    assign PEND_HIT1 = !RST && (RADDR1 != 5'd0) && hit1_any;
    assign PEND_HIT2 = !RST && (RADDR2 != 5'd0) && hit2_any;

    always_comb begin
        starve_nxt = starve_cnt;
        if (pop || !not_empty) begin
            starve_nxt = '0;
        end else if (blocked && (starve_cnt != SW'(STARVE_LIMIT))) begin
            starve_nxt = starve_cnt + SW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            q_valid    <= '0;
            q_kill     <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
            stall_q    <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (p_busy && q_valid[i] && (q_addr[i] == P_WADDR)) q_kill[i] <= 1'b1;
            end
            if (pop) begin
                q_valid[rd_ptr] <= 1'b0;
                q_kill[rd_ptr]  <= 1'b0;
                rd_ptr          <= rd_ptr + PW'(1);
            end
            // A same-cycle pipeline write to this register is newer, so store it dead.
            if (store) begin
                q_valid[wr_ptr] <= 1'b1;
                q_kill[wr_ptr]  <= p_busy && (P_WADDR == L_WADDR);
                wr_ptr          <= wr_ptr + PW'(1);
            end
            case ({store, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            starve_cnt <= starve_nxt;
            stall_q    <= (starve_nxt == SW'(STARVE_LIMIT));
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST && store) begin
            q_addr[wr_ptr] <= L_WADDR;
            q_data[wr_ptr] <= L_WDATA;
        end
    end

endmodule
